// File: rtl/fifo_display_scan_if.sv
// FIFO-side bus of the seven-segment scan driver: occupancy/head/empty from the
// control unit plus the register file's second combinational read port.
interface fifo_display_scan_if;
    logic [7:0] valid;
    logic [2:0] head;
    logic       emp;
    logic [3:0] rd2;
    logic [2:0] ra2;

    // master = FIFO side (control unit + register file), slave = display driver
    modport master (output valid, head, emp, rd2, input ra2);
    modport slave  (input valid, head, emp, rd2, output ra2);
endinterface

// File: rtl/fifo_display_scan.sv
// Time-multiplexes the 8 FIFO entries onto an 8-digit common-anode display.
// Define HEAD_BLINK_EN to blink the head digit every BLINK_FRAMES frames.
module fifo_display_scan #(
    parameter int SCAN_DIV = 100000     // clk cycles per digit slot, >= 2
`ifdef HEAD_BLINK_EN
    , parameter int BLINK_FRAMES = 128  // frames per blink half-period
`endif
) (
    input  logic                clk,
    input  logic                rst,
    fifo_display_scan_if.slave  bus,
    output logic [7:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    scan_idx_q, scan_idx_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick;
    logic          is_head;
    logic          head_blank;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; out-of-range values show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

`ifdef HEAD_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (tick && scan_idx_q == 3'd7) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign head_blank = phase_q && is_head;
`else
    assign head_blank = 1'b0;
`endif

    assign tick    = (presc_q == PW'(SCAN_DIV - 1));
    assign is_head = (scan_idx_q == bus.head);

    // NOTE: every always_comb output is given a hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        scan_idx_d = scan_idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        // rd2 and the FIFO status are only sampled here, at the start of a slot
        if (tick) begin
            an_d       = ~(8'b1 << scan_idx_q);
            seg_d      = bus.valid[scan_idx_q] ? decode(bus.rd2) : 7'h7F;
            dp_d       = !(is_head && !bus.emp);
            scan_idx_d = scan_idx_q + 3'd1;
            if (head_blank) begin
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and wins over a pending tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            scan_idx_q <= 3'd0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.ra2 = scan_idx_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_fifo_display_scan.sv
// Directed bench for fifo_display_scan with SCAN_DIV=4 (and BLINK_FRAMES=2
// when HEAD_BLINK_EN is defined); register file modelled as a small array.
module tb_fifo_display_scan;

    logic       clk;
    logic       rst;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] regs [8];
    logic [2:0] slot;
    int         n_vec;
    int         n_err;

    fifo_display_scan_if bus ();

    assign bus.rd2 = regs[bus.ra2];

    fifo_display_scan #(
        .SCAN_DIV(4)
`ifdef HEAD_BLINK_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg),
        .dp  (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  valid;
        logic [2:0]  head;
        logic        emp;
        logic [31:0] regs;     // entry i at [4i+:4]
        logic [55:0] exp_seg;  // digit i at [7i+:7]
        logic [7:0]  exp_dp;   // digit i at bit i
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        step(4);
        slot = slot + 3'd1;
    endtask

    task automatic load_regs(input logic [31:0] r);
        for (int i = 0; i < 8; i++) regs[i] = r[4*i +: 4];
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        slot  = 3'd0;

        vecs[0] = '{valid: 8'hFF, head: 3'd7, emp: 1'b0, regs: 32'h7654_3210,
                    exp_seg: {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40},
                    exp_dp: 8'b0111_1111};
        vecs[1] = '{valid: 8'b1000_0011, head: 3'd1, emp: 1'b0, regs: 32'h7654_3210,
                    exp_seg: {7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40},
                    exp_dp: 8'b1111_1101};
        vecs[2] = '{valid: 8'hFF, head: 3'd0, emp: 1'b0, regs: 32'h246F_C598,
                    exp_seg: {7'h24, 7'h19, 7'h02, 7'h3F, 7'h3F, 7'h12, 7'h10, 7'h00},
                    exp_dp: 8'b1111_1110};
        vecs[3] = '{valid: 8'h00, head: 3'd3, emp: 1'b1, regs: 32'h246F_C598,
                    exp_seg: {8{7'h7F}}, exp_dp: 8'hFF};
        vecs[4] = '{valid: 8'hFF, head: 3'd2, emp: 1'b1, regs: 32'h246F_C598,
                    exp_seg: {7'h24, 7'h19, 7'h02, 7'h3F, 7'h3F, 7'h12, 7'h10, 7'h00},
                    exp_dp: 8'hFF};

        // Reset held 3 cycles with a full queue already presented
        rst       = 1'b1;
        load_regs(32'h7654_3210);
        bus.valid = 8'hFF;
        bus.head  = 3'd7;
        bus.emp   = 1'b0;
        step(3);
        check("reset_an", 32'(an), 32'h0FF);
        check("reset_seg", 32'(seg), 32'h07F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_ra2", 32'(bus.ra2), 32'h0);

        // No digit lights until the 4th edge after release
        rst = 1'b0;
        step(3);
        check("pre_tick_an", 32'(an), 32'h0FF);
        check("pre_tick_seg", 32'(seg), 32'h07F);
        step(1);
        slot = 3'd1;
        check("first_tick_an", 32'(an), 32'h0FE);
        check("first_tick_seg", 32'(seg), 32'h040);
        check("first_tick_dp", 32'(dp), 32'h1);
        check("first_tick_ra2", 32'(bus.ra2), 32'h1);

        // One full frame per table entry, aligned to digit 0
        for (int v = 0; v < 5; v++) begin
            load_regs(vecs[v].regs);
            bus.valid = vecs[v].valid;
            bus.head  = vecs[v].head;
            bus.emp   = vecs[v].emp;
            while (slot != 3'd0) next_tick();
            for (int d = 0; d < 8; d++) begin
                logic [7:0] exp_an;
                exp_an = ~(8'b1 << d);
                next_tick();
                check($sformatf("v%0d_d%0d_an", v, d), 32'(an), 32'(exp_an));
                check($sformatf("v%0d_d%0d_seg", v, d), 32'(seg), 32'(vecs[v].exp_seg[7*d +: 7]));
                check($sformatf("v%0d_d%0d_dp", v, d), 32'(dp), 32'(vecs[v].exp_dp[d]));
                check($sformatf("v%0d_d%0d_ra2", v, d), 32'(bus.ra2), 32'(slot));
            end
        end

        // Outputs hold between ticks even when inputs change mid-slot
        bus.valid = 8'h00;
        step(2);
        check("hold_an", 32'(an), 32'h07F);
        check("hold_seg", 32'(seg), 32'h024);
        check("hold_dp", 32'(dp), 32'h1);
        bus.valid = 8'hFF;
        step(2);
        slot = slot + 3'd1;
        check("after_hold_an", 32'(an), 32'h0FE);

        // Reset asserted mid-slot with scan_idx away from zero
        next_tick();
        next_tick();
        step(2);
        rst = 1'b1;
        step(1);
        check("midrst_an", 32'(an), 32'h0FF);
        check("midrst_seg", 32'(seg), 32'h07F);
        check("midrst_dp", 32'(dp), 32'h1);
        check("midrst_ra2", 32'(bus.ra2), 32'h0);
        rst  = 1'b0;
        slot = 3'd0;
        step(3);
        check("midrst_pre_tick_an", 32'(an), 32'h0FF);
        step(1);
        slot = 3'd1;
        check("midrst_tick_an", 32'(an), 32'h0FE);
        check("midrst_tick_seg", 32'(seg), 32'h000);
        check("midrst_tick_dp", 32'(dp), 32'h1);

`ifdef HEAD_BLINK_EN
        // Head on digit 0: visible frames 0-1, blank 2-3, visible again at 4
        load_regs(32'h7654_3210);
        bus.valid = 8'hFF;
        bus.head  = 3'd0;
        bus.emp   = 1'b0;
        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        slot = 3'd0;
        for (int f = 0; f < 5; f++) begin
            for (int d = 0; d < 8; d++) begin
                next_tick();
                if (d == 0) begin
                    logic blank;
                    blank = (f == 2 || f == 3);
                    check($sformatf("blink_f%0d_seg", f), 32'(seg), blank ? 32'h07F : 32'h040);
                    check($sformatf("blink_f%0d_dp", f), 32'(dp), blank ? 32'h1 : 32'h0);
                end else if (d == 1) begin
                    check($sformatf("blink_f%0d_d1_seg", f), 32'(seg), 32'h079);
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_display_scan.md
Name: fifo_display_scan

Overview:
- Read-side display driver for the 8-entry, 4-bit queue register file used by the FIFO list control unit.
- Time-multiplexes all 8 entries onto an 8-digit common-anode seven-segment display.
- Reads entries through the register file's second, combinational read port.
- Blanks invalid slots and marks the queue head with the decimal point.
- Sits beside the control unit in the FIFO top level and consumes its valid, head and emp outputs.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2.
- BLINK_FRAMES, 128, full 8-digit frames per blink half-period; used only with HEAD_BLINK_EN.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  8  per-entry occupancy from the control unit; bit i = entry i holds data.
- head  input  3  index of the queue head entry.
- emp  input  1  queue empty flag.
- rd2  input  4  register file second read port data; combinational from ra2.
- ra2  output  3  register file second read address.
- an  output  8  digit anodes, active-low, one-hot-low; bit i = digit i.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point cathode, active-low.

Behaviour:
- Reset:
  - Synchronous; applies only on a clk edge with rst=1, and is honoured mid-scan.
  - an=8'hFF, seg=7'h7F, dp=1, prescaler=0, scan_idx=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick=1 for one cycle when prescaler==SCAN_DIV-1.
  - First tick occurs at the SCAN_DIV-th edge after reset release.
- Read address:
  - ra2 = scan_idx, combinational.
  - rd2 is sampled only on the tick edge.
- Tick edge, all outputs updated together, registered:
  - an <= ~(8'b1 << scan_idx).
  - seg <= valid[scan_idx] ? decode(rd2) : 7'h7F.
  - dp <= (scan_idx==head && !emp) ? 0 : 1.
  - scan_idx <= scan_idx+1, wrapping 7->0.
- Latency and timing:
  - A digit reflects the entry state sampled at the start of its slot.
  - FIFO updates mid-slot appear on that digit's next visit, at most 8*SCAN_DIV cycles later.
  - Outputs hold steady between ticks.
- Decode, seg value (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10..15 (never legally enqueued) = 0111111, a dash on segment g only.
- Boundaries:
  - Empty queue: all valid=0, so every digit is blank and dp is never lit.
  - Full queue: valid=8'hFF, so all digits show.
  - Wrap-around occupancy (valid bits non-contiguous): blanking is decided per bit; no range logic in this block.
  - head==scan_idx while emp=1: dp stays off.
  - Exactly one an bit is low after the first tick; none are low during or after reset until then.

Optional Feature:
- Macro: HEAD_BLINK_EN.
- Defined:
  - Frame counter increments each time scan_idx wraps 7->0; it counts 0..BLINK_FRAMES-1, then wraps.
  - phase toggles on that wrap.
  - While phase=1, the head digit's seg is forced to 7'h7F and dp to 1 (head blinks).
  - Reset sets phase=0, so the head is visible; the frame counter resets to 0.
- Undefined:
  - No frame counter and no phase register.
  - Head is marked by a steady dp only.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Reset hold 3 cycles, release -> an=FF, seg=7F, dp=1 until the 4th edge; then an=FE, ra2 advances to 1.
- Entries 0..7 = 0..7, valid=FF, head=7, emp=0, run 32 cycles -> digits 0..7 show decodes 1000000..1111000 in order; dp=0 only in the an=7F slot.
- valid=8'b1000_0011 (wrapped), head=1 -> digits 2..6 blank (seg=7F); digits 0, 1 and 7 decoded; dp=0 on digit 1.
- Entry 3 holds 12 with valid[3]=1 -> digit 3 seg=0111111.
- emp=1, valid=0, head=3 -> all seg=7F, dp=1 for a full frame; assert rst mid-slot -> next edge an=FF, scan_idx=0.
- HEAD_BLINK_EN, head=0, full queue -> head digit visible for frames 0-1, blank (seg=7F, dp=1) for frames 2-3, visible again at frame 4.
